fu_complete_arbiter: RTL and testbench



---
 rtl/fu_complete_arbiter_pkg.sv | 35 +++
 rtl/fu_complete_arbiter_if.sv | 37 +++
 rtl/fu_complete_arbiter_rr_pick.sv | 52 +++++
 rtl/fu_complete_arbiter.sv | 139 +++++++++++++
 tb/tb_fu_complete_arbiter.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/fu_complete_arbiter_pkg.sv
// ============================================================================
// Module   : fu_complete_arbiter_pkg
// Brief    : Shared definitions for the complete-stage CDB arbiter. These are
//            the completion packet type, the FU index map and default sizes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fu_complete_arbiter_pkg;

  // Default geometry of the complete stage
  localparam int NUM_FU_DEF = 8;
  localparam int CDB_W_DEF  = 3;

  // Functional-unit index map (request vector bit positions)
  localparam int ALU_1  = 0;
  localparam int ALU_2  = 1;
  localparam int ALU_3  = 2;
  localparam int MULT_1 = 3;
  localparam int MULT_2 = 4;
  localparam int LS_1   = 5;
  localparam int LS_2   = 6;
  localparam int BRANCH = 7;

  // Completion packet carried from an FU onto a CDB slot
  typedef struct packed {
    logic [5:0]  dest_prn;     // destination physical register
    logic [31:0] result;       // computed value
    logic [4:0]  rob_idx;      // reorder-buffer entry being completed
    logic        take_branch;  // resolved branch direction
  } fu_complete_packet_t;

endpackage

`default_nettype wire

// File: rtl/fu_complete_arbiter_if.sv
// ============================================================================
// Module   : fu_complete_arbiter_if
// Brief    : FU-side request/packet bundle and CDB-side result bundle of the
//            complete-stage arbiter. master = FU/retire side, slave = arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fu_complete_arbiter_if
  import fu_complete_arbiter_pkg::*;
#(
  parameter int NUM_FU = NUM_FU_DEF,
  parameter int CDB_W  = CDB_W_DEF
);
  localparam int CNT_W = $clog2(CDB_W + 1);

  logic                                squash;
  logic [NUM_FU-1:0]                   fu_finish;
  fu_complete_packet_t [NUM_FU-1:0]    fu_c_packet_in;
  logic [NUM_FU-1:0]                   fu_c_stall;
  logic [CDB_W-1:0]                    cdb_valid;
  fu_complete_packet_t [CDB_W-1:0]     cdb_packet;
  logic [CNT_W-1:0]                    grant_cnt;

  modport master (
    output squash, fu_finish, fu_c_packet_in,
    input  fu_c_stall, cdb_valid, cdb_packet, grant_cnt
  );

  modport slave (
    input  squash, fu_finish, fu_c_packet_in,
    output fu_c_stall, cdb_valid, cdb_packet, grant_cnt
  );

endinterface

`default_nettype wire

// File: rtl/fu_complete_arbiter_rr_pick.sv
// ============================================================================
// Module   : fu_complete_arbiter_rr_pick
// Brief    : Finds the first set request bit at or after ptr_i, wrapping at
//            NUM_FU-1 -> 0 (works for non-power-of-2 NUM_FU).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fu_complete_arbiter_rr_pick #(
  parameter int NUM_FU = 8,
  parameter int IDX_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
  input  wire logic [NUM_FU-1:0] req_i,
  input  wire logic [IDX_W-1:0]  ptr_i,
  output logic                   found_o,
  output logic [IDX_W-1:0]       idx_o,
  output logic [NUM_FU-1:0]      onehot_o
);

  // (base + off) mod NUM_FU; one subtraction is enough since both are < NUM_FU
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                input int off);
    logic [IDX_W:0] sum;
    sum = {1'b0, base} + (IDX_W+1)'(off);
    if (sum >= (IDX_W+1)'(NUM_FU)) begin
      sum = sum - (IDX_W+1)'(NUM_FU);
    end
    return sum[IDX_W-1:0];
  endfunction

  // Scan farthest offset first so the nearest requester overwrites the result
  always_comb begin : p_pick
    logic [IDX_W-1:0] cand;
    cand     = '0;
    found_o  = 1'b0;
    idx_o    = '0;
    onehot_o = '0;
    for (int off = NUM_FU - 1; off >= 0; off--) begin
      cand = wrap_add(ptr_i, off);
      if (req_i[cand]) begin
        found_o = 1'b1;
        idx_o   = cand;
      end
    end
    if (found_o) begin
      onehot_o[idx_o] = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fu_complete_arbiter.sv
// ============================================================================
// Module   : fu_complete_arbiter
// Brief    : Grants up to CDB_W of NUM_FU finishing functional units per cycle
//            in round-robin order. Winners are registered onto the CDB and
//            losers get a combinational stall.
//            Optional feature macro: BRANCH_PRIORITY_EN. When defined, a
//            finishing branch unit always takes slot 0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fu_complete_arbiter
  import fu_complete_arbiter_pkg::*;
#(
  parameter int NUM_FU     = NUM_FU_DEF,
  parameter int CDB_W      = CDB_W_DEF,
  parameter int BRANCH_IDX = BRANCH
) (
  input  wire logic              clock,
  input  wire logic              reset,
  fu_complete_arbiter_if.slave   bus
);

  localparam int IDX_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam int CNT_W = $clog2(CDB_W + 1);

`ifdef BRANCH_PRIORITY_EN
  localparam logic c_BRANCH_PRIO = 1'b1;
`else
  localparam logic c_BRANCH_PRIO = 1'b0;
`endif

  localparam logic [NUM_FU-1:0] c_BRANCH_MASK = NUM_FU'(1) << BRANCH_IDX;

  // State
  logic [IDX_W-1:0]                rr_ptr_q, rr_ptr_d;
  logic [CDB_W-1:0]                cdb_valid_q, cdb_valid_d;
  fu_complete_packet_t [CDB_W-1:0] cdb_packet_q, cdb_packet_d;
  logic [CNT_W-1:0]                grant_cnt_q, grant_cnt_d;

  // Arbitration wires
  logic [NUM_FU-1:0] w_req;
  logic [NUM_FU-1:0] w_pick_req;
  logic              w_br;
  logic [NUM_FU-1:0] w_grant;
  logic [NUM_FU-1:0] w_avail  [CDB_W];
  logic [CDB_W-1:0]  w_found;
  logic [IDX_W-1:0]  w_idx    [CDB_W];
  logic [NUM_FU-1:0] w_onehot [CDB_W];
  logic [IDX_W-1:0]  w_last_idx;
  logic              w_any_rr;

  // Reset and squash both suppress every request in the current cycle
  assign w_req      = (reset || bus.squash) ? '0 : bus.fu_finish;
  assign w_br       = c_BRANCH_PRIO & w_req[BRANCH_IDX];
  assign w_pick_req = c_BRANCH_PRIO ? (w_req & ~c_BRANCH_MASK) : w_req;

  // Cascade of pickers, each one blind to the FUs already picked above it
  assign w_avail[0] = w_pick_req;

  generate
    for (genvar k = 0; k < CDB_W; k++) begin : g_pick
      if (k > 0) begin : g_mask
        assign w_avail[k] = w_avail[k-1] & ~w_onehot[k-1];
      end
      fu_complete_arbiter_rr_pick #(
        .NUM_FU (NUM_FU),
        .IDX_W  (IDX_W)
      ) u_pick (
        .req_i    (w_avail[k]),
        .ptr_i    (rr_ptr_q),
        .found_o  (w_found[k]),
        .idx_o    (w_idx[k]),
        .onehot_o (w_onehot[k])
      );
    end
  endgenerate

  // Map picks onto slots (shifted by one when the branch owns slot 0)
  always_comb begin
    cdb_valid_d  = '0;
    cdb_packet_d = '0;
    w_grant      = '0;
    w_last_idx   = rr_ptr_q;
    w_any_rr     = 1'b0;
    grant_cnt_d  = '0;
    if (w_br) begin
      cdb_valid_d[0]      = 1'b1;
      cdb_packet_d[0]     = bus.fu_c_packet_in[BRANCH_IDX];
      w_grant[BRANCH_IDX] = 1'b1;
    end
    for (int k = 0; k < CDB_W; k++) begin
      if (w_found[k] && ((k + int'(w_br)) < CDB_W)) begin
        cdb_valid_d[k + int'(w_br)]  = 1'b1;
        cdb_packet_d[k + int'(w_br)] = bus.fu_c_packet_in[w_idx[k]];
        w_grant                      = w_grant | w_onehot[k];
        w_last_idx                   = w_idx[k];
        w_any_rr                     = 1'b1;
      end
    end
    for (int k = 0; k < CDB_W; k++) begin
      grant_cnt_d = grant_cnt_d + CNT_W'(cdb_valid_d[k]);
    end
  end

  // Pointer moves past the last round-robin winner; a lone priority branch
  // grant leaves it where it was
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (bus.squash) begin
      rr_ptr_d = '0;
    end else if (w_any_rr) begin
      rr_ptr_d = (w_last_idx == IDX_W'(NUM_FU - 1)) ? '0 : w_last_idx + IDX_W'(1);
    end
  end

  // Register the CDB slots and the round-robin pointer
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr_q     <= '0;
      cdb_valid_q  <= '0;
      cdb_packet_q <= '0;
      grant_cnt_q  <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      cdb_valid_q  <= cdb_valid_d;
      cdb_packet_q <= cdb_packet_d;
      grant_cnt_q  <= grant_cnt_d;
    end
  end

  assign bus.fu_c_stall = w_req & ~w_grant;
  assign bus.cdb_valid  = cdb_valid_q;
  assign bus.cdb_packet = cdb_packet_q;
  assign bus.grant_cnt  = grant_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_fu_complete_arbiter.sv
// ============================================================================
// Module   : tb_fu_complete_arbiter
// Brief    : Directed self-checking bench for fu_complete_arbiter.
//            BRANCH_PRIORITY_EN selects the branch-priority scenario instead
//            of the plain round-robin ones.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fu_complete_arbiter;
  import fu_complete_arbiter_pkg::*;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  fu_complete_arbiter_if #(.NUM_FU(8), .CDB_W(3)) bus ();

  fu_complete_arbiter #(
    .NUM_FU     (8),
    .CDB_W      (3),
    .BRANCH_IDX (7)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Distinct, non-zero packet per FU
  function automatic fu_complete_packet_t mkpkt(input int i);
    fu_complete_packet_t p;
    p.dest_prn    = 6'(i + 10);
    p.result      = 32'hA5A5_0000 | 32'(i);
    p.rob_idx     = 5'(i * 3 + 1);
    p.take_branch = (i == 7);
    return p;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Check registered slots; fu index < 0 means an empty (zeroed) slot
  task automatic chk_slots(input string tag, input logic [2:0] v,
                           input int f0, input int f1, input int f2,
                           input int cnt, input int ptr);
    int f [3];
    fu_complete_packet_t e;
    f[0] = f0; f[1] = f1; f[2] = f2;
    chk({tag, "_valid"}, 64'(bus.cdb_valid), 64'(v));
    for (int k = 0; k < 3; k++) begin
      e = (f[k] < 0) ? '0 : mkpkt(f[k]);
      chk($sformatf("%s_slot%0d", tag, k), 64'(bus.cdb_packet[k]), 64'(e));
    end
    chk({tag, "_cnt"}, 64'(bus.grant_cnt), 64'(cnt));
    chk({tag, "_ptr"}, 64'(dut.rr_ptr_q), 64'(ptr));
  endtask

  initial begin
    reset      = 1'b1;
    bus.squash = 1'b0;
    bus.fu_finish = 8'hFF;
    for (int i = 0; i < 8; i++) bus.fu_c_packet_in[i] = mkpkt(i);
    step();
    step();
    chk("rst_stall", 64'(bus.fu_c_stall), 64'h00);
    chk_slots("rst", 3'b000, -1, -1, -1, 0, 0);

`ifndef BRANCH_PRIORITY_EN
    // Two requesters, both granted
    reset = 1'b0;
    bus.fu_finish = 8'h12;
    #1;
    chk("t1_stall", 64'(bus.fu_c_stall), 64'h00);
    step();
    chk_slots("t1", 3'b011, 1, 4, -1, 2, 5);

    // Squash with everyone requesting
    bus.squash = 1'b1;
    bus.fu_finish = 8'hFF;
    #1;
    chk("t4_stall", 64'(bus.fu_c_stall), 64'h00);
    step();
    chk_slots("t4", 3'b000, -1, -1, -1, 0, 0);

    // All eight requesting and held
    bus.squash = 1'b0;
    #1;
    chk("t2c0_stall", 64'(bus.fu_c_stall), 64'hF8);
    step();
    chk_slots("t2c0", 3'b111, 0, 1, 2, 3, 3);
    chk("t2c1_stall", 64'(bus.fu_c_stall), 64'hC7);
    step();
    chk_slots("t2c1", 3'b111, 3, 4, 5, 3, 6);
    chk("t2c2_stall", 64'(bus.fu_c_stall), 64'h3E);
    step();
    chk_slots("t2c2", 3'b111, 6, 7, 0, 3, 1);

    // Wrap from pointer 6
    bus.squash = 1'b1;
    step();
    bus.squash = 1'b0;
    bus.fu_finish = 8'h20;
    step();
    chk_slots("t3pre", 3'b001, 5, -1, -1, 1, 6);
    bus.fu_finish = 8'h87;
    #1;
    chk("t3_stall", 64'(bus.fu_c_stall), 64'h04);
    step();
    chk_slots("t3", 3'b111, 7, 0, 1, 3, 2);

    // Reset mid-stream
    bus.squash = 1'b1;
    bus.fu_finish = 8'hFF;
    step();
    bus.squash = 1'b0;
    step();
    step();
    chk("t5_ptr_pre", 64'(dut.rr_ptr_q), 64'd6);
    reset = 1'b1;
    #1;
    chk("t5_rst_stall", 64'(bus.fu_c_stall), 64'h00);
    step();
    chk_slots("t5rst", 3'b000, -1, -1, -1, 0, 0);
    reset = 1'b0;
    #1;
    chk("t5_stall", 64'(bus.fu_c_stall), 64'hF8);
    step();
    chk_slots("t5", 3'b111, 0, 1, 2, 3, 3);

    // Idle cycle: pointer holds, no stalls
    bus.fu_finish = 8'h00;
    #1;
    chk("idle_stall", 64'(bus.fu_c_stall), 64'h00);
    step();
    chk_slots("idle", 3'b000, -1, -1, -1, 0, 3);
`else
    // Branch priority with everyone requesting
    reset = 1'b0;
    bus.fu_finish = 8'hFF;
    #1;
    chk("bp_stall", 64'(bus.fu_c_stall), 64'h7C);
    step();
    chk_slots("bp", 3'b111, 7, 0, 1, 3, 2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
